// File: rtl/echo_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : echo_responder                                               |
// | Description : Ultrasonic ranging echo emulator. A synchronized trig high   |
// |               pulse of at least TRIG_MIN cycles arms a measurement. After  |
// |               ECHO_DELAY cycles an echo pulse is produced whose width      |
// |               encodes distance_cm (or TIMEOUT_CYCLES when out of range),   |
// |               followed by a HOLDOFF dead time.                             |
// | Ports       : clock        - rising-edge clock for all logic               |
// |               resetn       - asynchronous active-low reset                 |
// |               enable       - 1 = accept new triggers                       |
// |               trig         - asynchronous trigger input                    |
// |               distance_cm  - emulated target distance (cm, unsigned)       |
// |               echo         - registered echo pulse                         |
// |               busy         - high whenever the FSM is not IDLE             |
// |               short_trig   - one-cycle pulse on a too-short trigger        |
// |               meas_count   - echo pulses produced, wraps 255 -> 0          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module echo_responder #(
  parameter int unsigned TRIG_MIN       = 500,
  parameter int unsigned ECHO_DELAY     = 25000,
  parameter int unsigned CYCLES_PER_CM  = 2900,
  parameter int unsigned MAX_CM         = 400,
  parameter int unsigned TIMEOUT_CYCLES = 1900000,
  parameter int unsigned HOLDOFF        = 50000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic       trig,
  input  logic [8:0] distance_cm,
  output logic       echo,
  output logic       busy,
  output logic       short_trig,
  output logic [7:0] meas_count
);

  localparam int TW = $clog2(TRIG_MIN + 2);
  localparam int CW = 32;

  localparam logic [TW-1:0] C_TRIG_MIN  = TW'(TRIG_MIN);
  localparam logic [CW-1:0] C_ECHO_LAST = CW'(ECHO_DELAY - 1);
  localparam logic [CW-1:0] C_HOLD_LAST = CW'(HOLDOFF - 1);
  localparam logic [CW-1:0] C_CPC       = CW'(CYCLES_PER_CM);
  localparam logic [CW-1:0] C_MAX_CM    = CW'(MAX_CM);
  localparam logic [CW-1:0] C_TIMEOUT   = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TRIG  = 3'd1,
    S_DELAY = 3'd2,
    S_ECHO  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  // Registered state
  logic          r_trig_meta;
  logic          r_ts;
  state_t        r_state;
  logic [TW-1:0] r_tcnt;
  logic [CW-1:0] r_cnt;
  logic [8:0]    r_cm;
  logic [CW-1:0] r_product;
  logic          r_armed;

  // Next-state values
  state_t        w_state;
  logic [TW-1:0] w_tcnt;
  logic [CW-1:0] w_cnt;
  logic          w_echo;
  logic          w_short;
  logic [7:0]    w_count;
  logic          w_latch;
  logic          w_armed;
  logic          w_cm_in_range;
  logic [CW-1:0] w_width;

  // The raw product is registered at the accept edge together with cm_q;
  // the range decision is taken from cm_q so the latched distance alone
  // determines the pulse width.
  assign w_cm_in_range = (r_cm != 9'd0) && (CW'(r_cm) <= C_MAX_CM);
  assign w_width       = w_cm_in_range ? r_product : C_TIMEOUT;

  assign busy = (r_state != S_IDLE);

  always_comb begin
    w_state = r_state;
    w_tcnt  = r_tcnt;
    w_cnt   = r_cnt;
    w_echo  = echo;
    w_short = 1'b0;
    w_count = meas_count;
    w_latch = 1'b0;
    // A trigger is only re-armed once ts has been seen low. A high level
    // observed outside IDLE (including across HOLD -> IDLE) disarms it, so a
    // trig held through the hold-off is not mistaken for a new request.
    if (!r_ts) begin
      w_armed = 1'b1;
    end else if (r_state != S_IDLE) begin
      w_armed = 1'b0;
    end else begin
      w_armed = r_armed;
    end

    unique case (r_state)
      S_IDLE: begin
        if (enable && r_ts && r_armed) begin
          w_state = S_TRIG;
          w_tcnt  = TW'(1);
        end
      end
      S_TRIG: begin
        if (r_ts) begin
          if (r_tcnt < C_TRIG_MIN) begin
            w_tcnt = r_tcnt + TW'(1);
          end
        end else if (r_tcnt >= C_TRIG_MIN) begin
          w_state = S_DELAY;
          w_cnt   = '0;
          w_latch = 1'b1;
        end else begin
          w_state = S_IDLE;
          w_short = 1'b1;
        end
      end
      S_DELAY: begin
        if (r_cnt == C_ECHO_LAST) begin
          w_state = S_ECHO;
          w_echo  = 1'b1;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_ECHO: begin
        if (r_cnt == w_width - CW'(1)) begin
          w_state = S_HOLD;
          w_echo  = 1'b0;
          w_count = meas_count + 8'd1;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_HOLD: begin
        if (r_cnt == C_HOLD_LAST) begin
          w_state = S_IDLE;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state = S_IDLE;
        w_echo  = 1'b0;
        w_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_trig_meta <= 1'b0;
      r_ts        <= 1'b0;
      r_state     <= S_IDLE;
      r_tcnt      <= '0;
      r_cnt       <= '0;
      r_cm        <= '0;
      r_product   <= '0;
      r_armed     <= 1'b0;
      echo        <= 1'b0;
      short_trig  <= 1'b0;
      meas_count  <= '0;
    end else begin
      r_trig_meta <= trig;
      r_ts        <= r_trig_meta;
      r_state     <= w_state;
      r_tcnt      <= w_tcnt;
      r_cnt       <= w_cnt;
      r_armed     <= w_armed;
      echo        <= w_echo;
      short_trig  <= w_short;
      meas_count  <= w_count;
      if (w_latch) begin
        r_cm      <= distance_cm;
        r_product <= CW'(distance_cm) * C_CPC;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_echo_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_echo_responder                                            |
// | Description : Scoreboard bench for echo_responder with small parameters.   |
// |               Stimulus pushes expected echo/short events; a monitor on the |
// |               falling clock edge pops and compares them.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_echo_responder;

  localparam int TRIG_MIN       = 8;
  localparam int ECHO_DELAY     = 20;
  localparam int CYCLES_PER_CM  = 3;
  localparam int MAX_CM         = 40;
  localparam int TIMEOUT_CYCLES = 150;
  localparam int HOLDOFF        = 30;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       enable = 1'b0;
  logic       trig = 1'b0;
  logic [8:0] distance_cm = '0;
  logic       echo;
  logic       busy;
  logic       short_trig;
  logic [7:0] meas_count;

  echo_responder #(
    .TRIG_MIN       (TRIG_MIN),
    .ECHO_DELAY     (ECHO_DELAY),
    .CYCLES_PER_CM  (CYCLES_PER_CM),
    .MAX_CM         (MAX_CM),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .HOLDOFF        (HOLDOFF)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .enable      (enable),
    .trig        (trig),
    .distance_cm (distance_cm),
    .echo        (echo),
    .busy        (busy),
    .short_trig  (short_trig),
    .meas_count  (meas_count)
  );

  always #5 clock = ~clock;

  // Rising-edge counter: at the falling edge after rising edge n, cyc == n.
  longint cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    longint rise;
    longint width;
  } echo_exp_t;

  echo_exp_t exp_q[$];
  longint    short_q[$];
  int        exp_meas = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference rule: in-range distances scale linearly, anything else times out.
  function automatic longint ref_width(input int d);
    if (d >= 1 && d <= MAX_CM) return longint'(d * CYCLES_PER_CM);
    return longint'(TIMEOUT_CYCLES);
  endfunction

  // ---------------- monitor ----------------
  bit        in_echo = 1'b0;
  bit        short_prev = 1'b0;
  bit        have_cur = 1'b0;
  echo_exp_t cur;
  longint    echo_start = 0;

  always @(negedge clock) begin
    if (!resetn) begin
      in_echo    = 1'b0;
      short_prev = 1'b0;
      have_cur   = 1'b0;
    end else begin
      if (echo && !in_echo) begin
        in_echo    = 1'b1;
        echo_start = cyc;
        check("busy_at_rise", longint'(busy), 1);
        check("meas_at_rise", longint'(meas_count), longint'(exp_meas));
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          have_cur = 1'b0;
          $display("FAIL echo_unexpected: echo rose at cycle %0d, expected no echo", cyc);
        end else begin
          cur      = exp_q.pop_front();
          have_cur = 1'b1;
          check("echo_rise", cyc, cur.rise);
        end
      end else if (!echo && in_echo) begin
        in_echo = 1'b0;
        if (have_cur) begin
          check("echo_width", cyc - echo_start, cur.width);
          exp_meas = (exp_meas + 1) % 256;
        end
        check("meas_at_fall", longint'(meas_count), longint'(exp_meas));
      end

      if (short_trig) begin
        if (short_prev) begin
          n_cmp++;
          n_bad++;
          $display("FAIL short_len: short_trig still high at cycle %0d, expected 1-cycle pulse", cyc);
        end else if (short_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL short_unexpected: short_trig at cycle %0d, expected none", cyc);
        end else begin
          check("short_at", cyc, short_q.pop_front());
        end
        check("busy_at_short", longint'(busy), 0);
        check("echo_at_short", longint'(echo), 0);
      end
      short_prev = short_trig;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_to(input longint t);
    while (cyc < t) @(negedge clock);
  endtask

  // One trigger of n cycles at distance d. Accept edge F is three edges after
  // the falling edge on which trig is dropped (two sync flops + FSM decision).
  task automatic run_meas(input int n, input int d, input bit drop_en, output longint done);
    longint dp;
    longint w;
    distance_cm = 9'(d);
    trig = 1'b1;
    tick(n);
    trig = 1'b0;
    dp = cyc;
    if (n >= TRIG_MIN) begin
      w = ref_width(d);
      exp_q.push_back('{dp + 3 + ECHO_DELAY, w});
      done = dp + 3 + ECHO_DELAY + w + HOLDOFF;
      tick(5);
      check("busy_in_delay", longint'(busy), 1);
      distance_cm = 9'($urandom);
      if (drop_en) enable = 1'b0;
      wait_to(done - 1);
      check("busy_end_hold", longint'(busy), 1);
      tick(1);
    end else begin
      short_q.push_back(dp + 3);
      done = dp + 4;
      wait_to(done);
    end
    check("busy_idle", longint'(busy), 0);
    enable = 1'b1;
    tick(1 + int'($urandom_range(0, 3)));
  endtask

  initial begin
    longint done;
    longint dp;
    longint r;
    longint g;

    #1 resetn = 1'b0;
    tick(3);
    check("reset_echo", longint'(echo), 0);
    check("reset_busy", longint'(busy), 0);
    check("reset_short", longint'(short_trig), 0);
    check("reset_meas", longint'(meas_count), 0);
    resetn = 1'b1;
    enable = 1'b1;
    tick(3);

    // Directed: nominal, boundaries, short trigger, out-of-range distances
    run_meas(TRIG_MIN + 4, 10, 1'b0, done);
    run_meas(TRIG_MIN, MAX_CM, 1'b0, done);
    run_meas(TRIG_MIN - 1, 10, 1'b0, done);
    run_meas(TRIG_MIN + 1, 0, 1'b0, done);
    run_meas(TRIG_MIN + 1, MAX_CM + 1, 1'b0, done);
    run_meas(TRIG_MIN + 1, 401, 1'b1, done);
    run_meas(TRIG_MIN + 2, 1, 1'b0, done);

    // enable low: a long trigger is ignored entirely
    enable = 1'b0;
    trig = 1'b1;
    tick(TRIG_MIN + 4);
    check("busy_when_disabled", longint'(busy), 0);
    trig = 1'b0;
    tick(6);
    check("busy_after_disabled", longint'(busy), 0);
    enable = 1'b1;
    tick(2);

    // Triggers during ECHO and during HOLD (held across IDLE entry) are ignored
    distance_cm = 9'd0;
    trig = 1'b1;
    tick(TRIG_MIN + 2);
    trig = 1'b0;
    dp = cyc;
    r = dp + 3 + ECHO_DELAY;
    g = r + TIMEOUT_CYCLES;
    exp_q.push_back('{r, longint'(TIMEOUT_CYCLES)});
    wait_to(r + 5);
    trig = 1'b1;
    tick(TRIG_MIN + 4);
    trig = 1'b0;
    wait_to(g + 3);
    trig = 1'b1;
    tick(HOLDOFF + 10);
    trig = 1'b0;
    tick(8);
    check("busy_after_held_trig", longint'(busy), 0);
    run_meas(TRIG_MIN + 3, 7, 1'b0, done);

    // Reset in the middle of an echo pulse
    distance_cm = 9'd20;
    trig = 1'b1;
    tick(TRIG_MIN + 2);
    trig = 1'b0;
    dp = cyc;
    r = dp + 3 + ECHO_DELAY;
    exp_q.push_back('{r, ref_width(20)});
    wait_to(r + 10);
    check("echo_before_reset", longint'(echo), 1);
    #2 resetn = 1'b0;
    #1;
    check("echo_async_reset", longint'(echo), 0);
    check("busy_async_reset", longint'(busy), 0);
    check("meas_async_reset", longint'(meas_count), 0);
    exp_meas = 0;
    exp_q.delete();
    short_q.delete();
    tick(3);
    resetn = 1'b1;
    tick(2);
    run_meas(TRIG_MIN + 3, 15, 1'b0, done);

    // Randomized mix of short/valid triggers and in/out-of-range distances
    for (int i = 0; i < 20; i++) begin
      run_meas(int'($urandom_range(TRIG_MIN - 3, TRIG_MIN + 5)),
               int'($urandom_range(0, 511)) % (($urandom_range(0, 3) == 0) ? 512 : MAX_CM + 2),
               1'($urandom_range(0, 1)), done);
    end

    // Counter wrap: 256 measurements from a fresh reset return meas_count to 0
    resetn = 1'b0;
    tick(2);
    exp_meas = 0;
    exp_q.delete();
    short_q.delete();
    resetn = 1'b1;
    tick(2);
    for (int i = 0; i < 256; i++) begin
      run_meas(TRIG_MIN + int'($urandom_range(0, 3)), int'($urandom_range(1, 6)), 1'b0, done);
    end
    check("meas_wrapped", longint'(meas_count), 0);

    tick(5);
    check("echo_q_left", longint'(exp_q.size()), 0);
    check("short_q_left", longint'(short_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
